seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display.
//  - Scans one digit per slot; segments and anodes are active-low.
//  - Displays the digit codes held in an active register. Host writes are staged and applied only at a frame boundary, so the display never tears.
//  - Sits between the datapath (counters, switches) and the board display pins.
// PARAMETERS
//  NUM_DIGITS   4       digits scanned, legal 1..8
//  REFRESH_DIV  100000  clk cycles per digit slot, legal >=2
//  HEX_MODE     0       1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 blank
// PORTS
//  clk        in   1             system clock, rising edge
//  rst        in   1             synchronous active-high reset
//  load       in   1             1-cycle strobe; captures digits_in/dp_in into pending reg
//  digits_in  in   4*NUM_DIGITS  4-bit code per digit; [3:0] = rightmost digit (idx 0)
//  dp_in      in   NUM_DIGITS    1 = decimal point lit for that digit
//  an         out  NUM_DIGITS    anode enables, active-low, registered
//  seg        out  7             {g,f,e,d,c,b,a}, active-low, registered
//  dp         out  1             decimal point, active-low, registered
//  frame_done out  1             1-cycle pulse when the last digit slot ends
//  update     out  1             1-cycle pulse when pending data becomes active
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - cnt=0, idx=0; active and pending regs =0; pend=0.
//  - an=all 1s, seg=7'h7F, dp=1, frame_done=0, update=0.
//  - rst mid-scan or mid-pending discards staged data; no update pulse.
//  Prescaler: cnt counts 0..REFRESH_DIV-1, then wraps. tick = (cnt==REFRESH_DIV-1).
//  - On tick: idx = (idx==NUM_DIGITS-1) ? 0 : idx+1.
//  - frame_done=1 in the cycle after a tick that had idx==NUM_DIGITS-1.
//  Staging:
//  - load=1 writes pending and sets pend.
//  - Repeated loads before the boundary overwrite pending; last write wins.
//  - Boundary = tick with idx==NUM_DIGITS-1. If pend=1 there: active<=pending, pend<=0, and update=1 next cycle.
//  - load in the boundary cycle: digits_in/dp_in go straight to active, pend<=0, update=1.
//  - No pend at the boundary: active is unchanged and update stays 0.
//  Outputs (registered; reflect the idx/cnt of the previous cycle, 1-cycle latency):
//  - Anti-ghosting: in the cycle when cnt==0, an=all 1s (dead slot). Otherwise an = ~(1<<idx).
//  - seg = decode(active code[idx]); dp = ~active_dp[idx].
//  Decode (active-low):
//  - 0:1000000  1:1111001  2:0100100  3:0110000  4:0011001
//  - 5:0010010  6:0000010  7:1111000  8:0000000  9:0010000
//  - HEX_MODE=1: A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110
//  - HEX_MODE=0: codes 10-15 give seg=1111111 (blank).
//  Defined output for every code; no latch, no held value.
//  NUM_DIGITS=1: idx is constant 0; every tick is a boundary.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//  - Defined: a digit with code 0 at a position above the highest nonzero digit of active gets seg=1111111.
//  - Digit idx 0 is never blanked. dp is still driven from active_dp.
//  - All-zero value shows a single "0" in idx 0.
//  - Undefined: every digit is decoded, leading zeros shown.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4 unless stated)
//  1 Reset: assert rst mid-scan -> next cycle an=4'b1111, seg=7'h7F, dp=1; pulses 0; after release, idx0 shows code 0 (seg=1000000).
//  2 Scan: load digits=16'h4321, dp=4'b0010 -> after boundary, update pulses once. Each slot: 1 dead cycle (an=1111), then 3 cycles an=1110,1101,1011,0111 with seg 1111001,0100100,0110000,0011001; dp=0 only on an=1101.
//  3 Staging: load 16'h1111 then 16'h2222 mid-frame -> displayed digits unchanged until the boundary, then all show 2. update pulses exactly once. load in the boundary cycle -> applied in that same boundary.
//  4 Decode: HEX_MODE=1, load 16'hFEDC -> seg 1000110,0100001,0000110,0001110. HEX_MODE=0 -> all 1111111.
//  5 Timing: frame_done period = 16 clks; cnt/idx wrap; NUM_DIGITS=1, REFRESH_DIV=2 -> frame_done and update coincide with every tick.
//  6 LEADING_ZERO_BLANK_EN: load 16'h0050 -> digits 3,2 blank, digit1=0010010, digit0=1000000. 16'h0000 -> only idx0 lit. Undefined -> leading zeros show 1000000.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous (tear-free) host updates.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seg7_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int HEX_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done,
    output logic                    update
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [4*NUM_DIGITS-1:0] pending_digits;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic                    pend;

    logic                    tick;
    logic                    last_slot;
    logic                    boundary;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;

    // Active-low {g,f,e,d,c,b,a}; every code yields a defined pattern.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = (HEX_MODE != 0) ? 7'b0001000 : SEG_BLANK;
            4'd11:   s = (HEX_MODE != 0) ? 7'b0000011 : SEG_BLANK;
            4'd12:   s = (HEX_MODE != 0) ? 7'b1000110 : SEG_BLANK;
            4'd13:   s = (HEX_MODE != 0) ? 7'b0100001 : SEG_BLANK;
            4'd14:   s = (HEX_MODE != 0) ? 7'b0000110 : SEG_BLANK;
            4'd15:   s = (HEX_MODE != 0) ? 7'b0001110 : SEG_BLANK;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign tick      = (cnt == CNT_LAST);
    assign last_slot = (idx == IDX_LAST);
    assign boundary  = tick && last_slot;

    always_comb begin
        cur_code = 4'd0;
        cur_dp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code = active_digits[4*i +: 4];
                cur_dp   = active_dp[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A slot is blanked when it and every digit above it are zero; slot 0 always shows.
    logic [NUM_DIGITS-1:0] nz_at_or_above;
    always_comb begin
        logic seen;
        seen           = 1'b0;
        nz_at_or_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen              = seen | (|active_digits[4*i +: 4]);
            nz_at_or_above[i] = seen;
        end
        cur_blank = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i) && !nz_at_or_above[i]) begin
                cur_blank = 1'b1;
            end
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    // The first cycle of each slot is dead so the previous digit does not ghost.
    always_comb begin
        an_next = '1;
        if (cnt != '0) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_next[i] = (idx != IDX_W'(i));
            end
        end
        seg_next = cur_blank ? SEG_BLANK : decode(cur_code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx <= last_slot ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // A load coinciding with the boundary bypasses staging and goes live immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_digits  <= '0;
            active_dp      <= '0;
            pending_digits <= '0;
            pending_dp     <= '0;
            pend           <= 1'b0;
            update         <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= boundary;
            update     <= 1'b0;
            if (boundary) begin
                if (load) begin
                    active_digits <= digits_in;
                    active_dp     <= dp_in;
                    pend          <= 1'b0;
                    update        <= 1'b1;
                end else if (pend) begin
                    active_digits <= pending_digits;
                    active_dp     <= pending_dp;
                    pend          <= 1'b0;
                    update        <= 1'b1;
                end
            end else if (load) begin
                pending_digits <= digits_in;
                pending_dp     <= dp_in;
                pend           <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: hex/blank decode instances (4 digits, 4-cycle slots) plus a 1-digit, 2-cycle instance.
// Expectations for leading-zero blanking follow the LEADING_ZERO_BLANK_EN build macro.
module tb_seg7_scan_mux;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;

    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic        fd_a, fd_b, fd_c;
    logic        upd_a, upd_b, upd_c;
    logic [0:0]  an_c;

    int compared   = 0;
    int mismatched = 0;
    int ecount     = 0;

    always #5 clk = ~clk;

    seg7_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a), .update(upd_a)
    );

    seg7_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b), .update(upd_b)
    );

    seg7_scan_mux #(.NUM_DIGITS(1), .REFRESH_DIV(2), .HEX_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in[3:0]), .dp_in(dp_in[0:0]),
        .an(an_c), .seg(seg_c), .dp(dp_c), .frame_done(fd_c), .update(upd_c)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One negedge later; outputs then reflect posedge number ecount-1.
    task automatic step();
        @(negedge clk);
        ecount++;
    endtask

    task automatic run_to(input int k);
        while (ecount < k + 1) step();
    endtask

    task automatic applyStimulus(input int at_edge, input logic [15:0] d, input logic [3:0] p);
        run_to(at_edge - 1);
        load      = 1'b1;
        digits_in = d;
        dp_in     = p;
        step();
        load      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_an",  16'(an_a), 16'h000F);
        checkOutput("rst_seg", 16'(seg_a), 16'h007F);
        checkOutput("rst_dp",  16'(dp_a), 16'h0001);
        checkOutput("rst_fd",  16'(fd_a), 16'h0000);
        checkOutput("rst_upd", 16'(upd_a), 16'h0000);
        rst = 1'b0; ecount = 0;

        run_to(0);  checkOutput("e0_dead", 16'(an_a), 16'h000F);
        run_to(1);
        checkOutput("e1_an",   16'(an_a), 16'h000E);
        checkOutput("e1_seg0", 16'(seg_a), 16'(S0));
        checkOutput("e1_dp",   16'(dp_a), 16'h0001);
        checkOutput("c_fd_e1", 16'(fd_c), 16'h0001);
        checkOutput("c_upd_e1",16'(upd_c), 16'h0000);

        applyStimulus(2, 16'h4321, 4'b0010);
        checkOutput("c_fd_e2", 16'(fd_c), 16'h0000);
        checkOutput("c_upd_e2",16'(upd_c), 16'h0000);
        run_to(3);
        checkOutput("c_upd_e3",16'(upd_c), 16'h0001);
        checkOutput("c_fd_e3", 16'(fd_c), 16'h0001);
        run_to(4);  checkOutput("c_dead",  16'(an_c), 16'h0001);
        run_to(5);
        checkOutput("c_seg",   16'(seg_c), 16'(S1));
        checkOutput("c_an",    16'(an_c), 16'h0000);
        checkOutput("c_upd_e5",16'(upd_c), 16'h0000);

        run_to(14);
        checkOutput("pre_an3", 16'(an_a), 16'h0007);
        checkOutput("pre_seg", 16'(seg_a), 16'(S0));
        checkOutput("pre_upd", 16'(upd_a), 16'h0000);
        run_to(15);
        checkOutput("bnd_upd", 16'(upd_a), 16'h0001);
        checkOutput("bnd_fd",  16'(fd_a), 16'h0001);
        run_to(16);
        checkOutput("post_dead",16'(an_a), 16'h000F);
        checkOutput("post_upd", 16'(upd_a), 16'h0000);
        checkOutput("post_fd",  16'(fd_a), 16'h0000);
        run_to(17);
        checkOutput("d0_an",  16'(an_a), 16'h000E);
        checkOutput("d0_seg", 16'(seg_a), 16'(S1));
        checkOutput("d0_dp",  16'(dp_a), 16'h0001);
        checkOutput("b_d0_seg",16'(seg_b), 16'(S1));
        run_to(21);
        checkOutput("d1_an",  16'(an_a), 16'h000D);
        checkOutput("d1_seg", 16'(seg_a), 16'(S2));
        checkOutput("d1_dp",  16'(dp_a), 16'h0000);
        run_to(25);
        checkOutput("d2_an",  16'(an_a), 16'h000B);
        checkOutput("d2_seg", 16'(seg_a), 16'(S3));
        checkOutput("d2_dp",  16'(dp_a), 16'h0001);
        run_to(29);
        checkOutput("d3_an",  16'(an_a), 16'h0007);
        checkOutput("d3_seg", 16'(seg_a), 16'(S4));
        run_to(30); checkOutput("fd_e30", 16'(fd_a), 16'h0000);
        run_to(31);
        checkOutput("fd_e31",  16'(fd_a), 16'h0001);
        checkOutput("upd_e31", 16'(upd_a), 16'h0000);

        applyStimulus(34, 16'h1111, 4'b0000);
        applyStimulus(38, 16'h2222, 4'b0000);
        run_to(45);
        checkOutput("stg_an",   16'(an_a), 16'h0007);
        checkOutput("stg_hold", 16'(seg_a), 16'(S4));
        run_to(46); checkOutput("stg_upd46", 16'(upd_a), 16'h0000);
        run_to(47); checkOutput("stg_upd47", 16'(upd_a), 16'h0001);
        run_to(48); checkOutput("stg_upd48", 16'(upd_a), 16'h0000);
        run_to(49); checkOutput("stg_d0", 16'(seg_a), 16'(S2));
        run_to(61); checkOutput("stg_d3", 16'(seg_a), 16'(S2));

        applyStimulus(63, 16'hFEDC, 4'b0000);
        checkOutput("bl_upd", 16'(upd_a), 16'h0001);
        checkOutput("bl_fd",  16'(fd_a), 16'h0001);
        run_to(64); checkOutput("bl_upd64", 16'(upd_a), 16'h0000);
        run_to(65);
        checkOutput("hex_c",   16'(seg_a), 16'(SC));
        checkOutput("blank_c", 16'(seg_b), 16'(SB));
        run_to(69); checkOutput("hex_d", 16'(seg_a), 16'(SD));
        run_to(73); checkOutput("hex_e", 16'(seg_a), 16'(SE));
        run_to(77);
        checkOutput("hex_f",   16'(seg_a), 16'(SF));
        checkOutput("blank_f", 16'(seg_b), 16'(SB));
        run_to(79);
        checkOutput("nopend_upd", 16'(upd_a), 16'h0000);
        checkOutput("nopend_fd",  16'(fd_a), 16'h0001);
        run_to(81); checkOutput("nopend_seg", 16'(seg_a), 16'(SC));

        applyStimulus(82, 16'h9999, 4'b1111);
        run_to(85); checkOutput("mid_an", 16'(an_a), 16'h000D);
        rst = 1'b1;
        step();
        checkOutput("mrst_an",  16'(an_a), 16'h000F);
        checkOutput("mrst_seg", 16'(seg_a), 16'h007F);
        checkOutput("mrst_dp",  16'(dp_a), 16'h0001);
        checkOutput("mrst_fd",  16'(fd_a), 16'h0000);
        checkOutput("mrst_upd", 16'(upd_a), 16'h0000);
        step();
        rst = 1'b0; ecount = 0;
        run_to(0);  checkOutput("r_dead", 16'(an_a), 16'h000F);
        run_to(1);
        checkOutput("r_seg", 16'(seg_a), 16'(S0));
        checkOutput("r_dp",  16'(dp_a), 16'h0001);
        run_to(15);
        checkOutput("r_upd", 16'(upd_a), 16'h0000);
        checkOutput("r_fd",  16'(fd_a), 16'h0001);
        run_to(17);
        checkOutput("r_discard_seg", 16'(seg_a), 16'(S0));
        checkOutput("r_discard_dp",  16'(dp_a), 16'h0001);

        applyStimulus(18, 16'h0050, 4'b1000);
        run_to(31); checkOutput("lz_upd", 16'(upd_a), 16'h0001);
        run_to(33); checkOutput("lz_d0", 16'(seg_a), 16'(S0));
        run_to(37); checkOutput("lz_d1", 16'(seg_a), 16'(S5));
        run_to(41); checkOutput("lz_d2", 16'(seg_a), 16'(LZ));
        run_to(45);
        checkOutput("lz_d3",    16'(seg_a), 16'(LZ));
        checkOutput("lz_d3_dp", 16'(dp_a), 16'h0000);
        applyStimulus(47, 16'h0000, 4'b0000);
        run_to(49); checkOutput("z_d0", 16'(seg_a), 16'(S0));
        run_to(53); checkOutput("z_d1", 16'(seg_a), 16'(LZ));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
